riscv_timer: RTL

//  Memory-mapped machine timer (mtime/mtimecmp) feeding the memory stage's load mux
//  (timer read-data input) and the core's machine-timer interrupt line.

---
 rtl/riscv_timer_if.sv | 14 +
 rtl/riscv_timer.sv | 50 +++++
 2 files changed

// File: rtl/riscv_timer_if.sv
// Memory-stage access bus into the machine timer: store/load strobes in, read data and irq out.
interface riscv_timer_if;
  logic        sel;
  logic        wren;
  logic [3:0]  addr;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic        stall;
  logic [63:0] rdata;
  logic        irq;

  modport master (output sel, wren, addr, size, wdata, stall, input rdata, irq);
  modport slave  (input sel, wren, addr, size, wdata, stall, output rdata, irq);
endinterface

// File: rtl/riscv_timer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, and a registered level interrupt.
module riscv_timer #(
  parameter int unsigned PRESCALE  = 100,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          i_riscv_timer_clk,
  input  logic          i_riscv_timer_rst_n,
  riscv_timer_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic [63:0]   mtime, mtimecmp, mtime_nxt, mtimecmp_nxt;
  logic [63:0]   base, wr_val;
  logic          tick, wr_ok, irq_q;

  assign tick = (pcnt == PMAX);
  assign base = bus.addr[3] ? mtimecmp : mtime;

  // Word stores merge into the addressed register's pre-write value; a misaligned
  // double (addr[2]=1) or any unaligned address is dropped entirely.
  always_comb begin
    wr_ok = bus.sel & bus.wren & ~bus.stall & bus.size[1] &
            (bus.addr[1:0] == 2'b00) & ~(bus.size[0] & bus.addr[2]);
    if (bus.size[0])       wr_val = bus.wdata;
    else if (bus.addr[2])  wr_val = {bus.wdata[31:0], base[31:0]};
    else                   wr_val = {base[63:32], bus.wdata[31:0]};
    mtime_nxt    = (wr_ok & ~bus.addr[3]) ? wr_val : mtime + 64'(tick);
    mtimecmp_nxt = (wr_ok &  bus.addr[3]) ? wr_val : mtimecmp;
  end

  always_ff @(posedge i_riscv_timer_clk or negedge i_riscv_timer_rst_n) begin
    if (!i_riscv_timer_rst_n) begin
      pcnt     <= '0;
      mtime    <= '0;
      mtimecmp <= CMP_RESET;
      irq_q    <= 1'b0;
    end else begin
      pcnt     <= tick ? '0 : pcnt + PW'(1);
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      irq_q    <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

  assign bus.rdata = !bus.sel     ? 64'b0 :
                     bus.addr[2]  ? {32'b0, base[63:32]} : base;
  assign bus.irq   = irq_q;
endmodule
